// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and feeds sha256_core.
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mode_in,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  output logic         busy,
  output logic         msg_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_ISSUE,
    S_WAIT
  } state_e;

  localparam int ZW = 61 - LEN_W;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         idx_q, idx_d;
  logic               first_q, first_d;
  logic               marker_q, marker_d;
  logic               final_q, final_d;
  logic               last_q, last_d;
  logic               wfirst_q, wfirst_d;
  logic               mode_q, mode_d;
  logic [511:0]       block_q, block_d;

  logic               acc;
  logic [6:0]         free;
  logic [63:0]        len64;

  assign len64 = {{ZW{1'b0}}, cnt_q, 3'b000};
  assign free  = marker_q ? {1'b0, idx_q}
                          : {1'b0, idx_q} + 7'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    first_d   = first_q;
    marker_d  = marker_q;
    final_d   = final_q;
    last_d    = last_q;
    wfirst_d  = wfirst_q;
    mode_d    = mode_q;
    block_d   = block_q;
    acc       = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    msg_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        acc = 1'b1;
        if (in_valid) begin
          mode_d             = mode_in;
          block_d            = '0;
          block_d[511 -: 8]  = in_data;
          idx_d              = 6'd1;
          cnt_d              = LEN_W'(1);
          last_d             = 1'b0;
          marker_d           = 1'b0;
          final_d            = 1'b0;
          state_d            = in_last ? S_PAD : S_FILL;
        end
      end
      S_FILL: begin
        acc = 1'b1;
        if (in_valid) begin
          block_d[{~idx_q, 3'b111} -: 8] = in_data;
          idx_d = idx_q + 6'd1;
          cnt_d = cnt_q + LEN_W'(1);
          if (idx_q == 6'd63) begin
            state_d = S_ISSUE;
            final_d = 1'b0;
            if (in_last) last_d = 1'b1;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (!marker_q) begin
          block_d[{~idx_q, 3'b111} -: 8] = 8'h80;
          marker_d = 1'b1;
        end
        // Length only fits if it does not collide with the marker.
        if (free <= 7'd56) begin
          block_d[63:0] = len64;
          final_d       = 1'b1;
        end else begin
          final_d = 1'b0;
          last_d  = 1'b1;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = ~first_q;
          first_d   = 1'b0;
          wfirst_d  = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        wfirst_d = 1'b0;
        if (!wfirst_q && core_ready) begin
          if (final_q) begin
            msg_done = 1'b1;
            marker_d = 1'b0;
            first_d  = 1'b1;
            last_d   = 1'b0;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            block_d = '0;
            idx_d   = '0;
            state_d = last_q ? S_PAD : S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      marker_q <= 1'b0;
      final_q  <= 1'b0;
      last_q   <= 1'b0;
      wfirst_q <= 1'b0;
      mode_q   <= 1'b0;
      block_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      marker_q <= marker_d;
      final_q  <= final_d;
      last_q   <= last_d;
      wfirst_q <= wfirst_d;
      mode_q   <= mode_d;
      block_q  <= block_d;
    end
  end

  // Held low during reset so every output reads zero immediately.
  assign in_ready   = acc & reset_n;
  assign core_mode  = mode_q;
  assign core_block = block_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: random messages against a
// byte-level FIPS 180-4 padding model, with a simple core ready model.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mode_in = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic         core_ready = 1'b1;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         busy;
  logic         msg_done;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_in    (mode_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .core_ready (core_ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_mode  (core_mode),
    .core_block (core_block),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    bit           init;
    bit           mode;
    bit           fin;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   msg_q[$];
  int           vecs = 0;
  int           errs = 0;
  int           dones = 0;
  int           msgs = 0;
  bit           stall = 1'b0;
  int           lat_max = 4;
  bit           lock = 1'b0;
  int           lock_age = 0;
  logic [511:0] lock_blk;
  bit           last_fin = 1'b0;

  function automatic void chk(string name, logic [511:0] act,
                              logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: pad the whole message as a byte list, then cut it into blocks.
  task automatic push_expected(input bit md);
    logic [7:0]   pad[$];
    logic [63:0]  bitlen;
    logic [511:0] b;
    exp_t         e;
    int           nblk;
    pad = msg_q;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
    nblk = pad.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      b = '0;
      for (int k = 0; k < 64; k++) b[511 - 8*k -: 8] = pad[j*64 + k];
      e.blk  = b;
      e.init = (j == 0);
      e.mode = md;
      e.fin  = (j == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (core_init || core_next) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL extra_block: got %0h expected none", core_block);
      end else begin
        e = exp_q.pop_front();
        chk("block", core_block, e.blk);
        chk("init", core_init, e.init);
        chk("next", core_next, !e.init);
        chk("mode", core_mode, e.mode);
        last_fin = e.fin;
        lock     = 1'b1;
        lock_age = 0;
        lock_blk = e.blk;
      end
    end else if (lock) begin
      lock_age++;
      chk("stable_blk", core_block, lock_blk);
      chk("in_ready_wait", in_ready, 1'b0);
      if (lock_age >= 2 && core_ready) lock = 1'b0;
    end
    if (msg_done) begin
      chk("done_after_final", last_fin, 1'b1);
      last_fin = 1'b0;
      dones++;
    end
  end

  // Core model: ready stays high the cycle after a pulse, then drops.
  initial begin
    bit seen;
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      seen = core_init || core_next;
      @(posedge clk);
      #1;
      if (seen) pend = 1'b1;
      else if (pend) begin
        pend = 1'b0;
        cnt  = $urandom_range(1, lat_max);
      end else if (cnt > 0) cnt--;
      core_ready = !stall && (cnt == 0);
    end
  end

  task automatic send(input bit md, input bit gaps, input int partial);
    int n;
    int t;
    n = (partial > 0) ? partial : msg_q.size();
    if (partial == 0) begin
      push_expected(md);
      msgs++;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (partial == 0) && (i == n - 1);
      mode_in  = (i == 0) ? md : ~md;
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 3000) begin
          vecs++;
          errs++;
          $display("FAIL in_ready_timeout: got 0 expected 1");
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (dones < msgs && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("done_count", 512'(dones), 512'(msgs));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_init"}, core_init, 1'b0);
    chk({tag, "_next"}, core_next, 1'b0);
    chk({tag, "_done"}, msg_done, 1'b0);
    chk({tag, "_mode"}, core_mode, 1'b0);
    chk({tag, "_block"}, core_block, 512'd0);
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    int n;
    int sel;
    #2;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_idle", in_ready, 1'b1);

    msg_q = '{8'h61, 8'h62, 8'h63};
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 0);
    wait_done();

    msg_q.delete();
    for (int i = 0; i < 55; i++) msg_q.push_back(8'(i));
    send(1'b0, 1'b0, 0);
    wait_done();

    foreach (n_list[j]) begin
      rand_msg(n_list[j]);
      send(1'(j), 1'b1, 0);
      wait_done();
    end

    stall = 1'b1;
    rand_msg(130);
    fork
      send(1'b1, 1'b0, 0);
      begin
        repeat (75) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_init", core_init, 1'b0);
          chk("stall_busy", busy, 1'b1);
          chk("stall_block", core_block, exp_q[0].blk);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    wait_done();

    rand_msg(100);
    send(1'b1, 1'b1, 30);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send(1'b0, 1'b0, 0);
    wait_done();

    for (int m = 0; m < 25; m++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) n = $urandom_range(1, 8);
      else if (sel == 1) n = $urandom_range(50, 70);
      else if (sel == 2) n = $urandom_range(110, 135);
      else n = $urandom_range(1, 200);
      lat_max = $urandom_range(1, 8);
      rand_msg(n);
      send(1'($urandom), 1'b1, 0);
      wait_done();
    end

    repeat (5) @(posedge clk);
    chk("exp_queue_empty", 512'(exp_q.size()), 512'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  int n_list[3] = '{56, 64, 63};

endmodule
